// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
// Shared definitions for the PS/2 keyboard path: scancode constants for the
// break/extended prefixes and the modifier keys, the sequencer state
// encoding, and a modifier classification helper.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_LANG   = 8'h0E;

    // Decode states (IDLE..EXT_BRK) followed by event states (ISSUE..CAPTURE)
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE
    } seq_state_e;

    function automatic logic is_modifier(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT) ||
               (code == SC_CAPS)   || (code == SC_LANG);
    endfunction

endpackage

// File: rtl/ps2_key_sequencer_char_fifo.sv
// char_fifo
// Small synchronous FIFO with registered storage. A push while full is
// accepted only if a pop happens in the same cycle.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   push, push_data    write request and data
//   pop                read request (ignored while empty)
//   head_data          current head entry (0 while empty)
//   full, empty        occupancy flags
module char_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
// Decodes the raw PS/2 byte stream (make, F0 break, E0 extended) into single
// key events for the scancode-to-ASCII translator, holds each scancode
// through the translator latency, captures the ASCII result and queues
// printable characters in a FIFO.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   rx_valid, rx_byte       raw byte strobe from the PS/2 receiver
//   scancode                to translator, stable for the whole event
//   push_down, push_up      one-cycle make/break pulses to translator
//   ascii_in                translator output
//   char_valid, char_data   FIFO non-empty flag and head character
//   char_ready              consumer pop request
//   overflow                one-cycle pulse when a byte or character is dropped
//   busy                    an event is being sequenced
// Build option: define KEY_REPEAT_EN to forward non-modifier typematic
// repeats as full make events; otherwise repeats are discarded in decode.
module ps2_key_sequencer
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned ASCII_LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] scancode,
    output logic       push_down,
    output logic       push_up,
    input  logic [7:0] ascii_in,
    output logic       char_valid,
    output logic [7:0] char_data,
    input  logic       char_ready,
    output logic       overflow,
    output logic       busy
);

    localparam int unsigned WAIT_W = $clog2(ASCII_LATENCY + 1);

    seq_state_e        state;
    logic [7:0]        held;
    logic [7:0]        pend_byte;
    logic              pend_valid;
    logic              ev_make;
    logic [WAIT_W-1:0] wait_cnt;

    logic              in_valid;
    logic [7:0]        in_byte;
    logic              is_repeat;
    logic              drop_make;
    logic              cap_push;
    logic              cap_drop;
    logic              fifo_full;
    logic              fifo_empty;

    // A buffered byte takes priority over a fresh one once decoding resumes
    assign in_valid  = !busy && (pend_valid || rx_valid);
    assign in_byte   = pend_valid ? pend_byte : rx_byte;
    assign is_repeat = (in_byte == held) && (held != '0);

`ifdef KEY_REPEAT_EN
    assign drop_make = is_repeat && is_modifier(in_byte);
`else
    assign drop_make = is_repeat;
`endif

    assign cap_push   = (state == ST_CAPTURE) && ev_make &&
                        !is_modifier(scancode) && (ascii_in != '0);
    assign cap_drop   = cap_push && fifo_full && !(char_valid && char_ready);
    assign char_valid = !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            scancode   <= '0;
            push_down  <= 1'b0;
            push_up    <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            held       <= '0;
            pend_byte  <= '0;
            pend_valid <= 1'b0;
            ev_make    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            push_down <= 1'b0;
            push_up   <= 1'b0;
            overflow  <= cap_drop;

            // Pending slot: fill while busy; while decoding it is consumed
            // this cycle and refilled by any byte arriving alongside.
            if (busy) begin
                if (rx_valid) begin
                    if (pend_valid) begin
                        overflow <= 1'b1;
                    end else begin
                        pend_valid <= 1'b1;
                        pend_byte  <= rx_byte;
                    end
                end
            end else if (pend_valid) begin
                pend_valid <= rx_valid;
                pend_byte  <= rx_byte;
            end

            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (in_byte == SC_BREAK) begin
                            state <= ST_BRK;
                        end else if (in_byte == SC_EXT) begin
                            state <= ST_EXT;
                        end else if (!drop_make) begin
                            scancode  <= in_byte;
                            push_down <= 1'b1;
                            ev_make   <= 1'b1;
                            held      <= in_byte;
                            busy      <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_BRK: begin
                    if (in_valid) begin
                        scancode <= in_byte;
                        push_up  <= 1'b1;
                        ev_make  <= 1'b0;
                        if (in_byte == held) held <= '0;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_EXT: begin
                    if (in_valid) state <= (in_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    if (in_valid) state <= ST_IDLE;
                end
                ST_ISSUE: begin
                    if (ASCII_LATENCY > 1) begin
                        wait_cnt <= WAIT_W'(ASCII_LATENCY - 2);
                        state    <= ST_WAIT;
                    end else begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) state <= ST_CAPTURE;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                ST_CAPTURE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cap_push),
        .push_data (ascii_in),
        .pop       (char_ready),
        .head_data (char_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
